// File: rtl/bpu_correct_queue_pkg.sv
// Shared types for the BPU correction queue: branch-type encoding, the prediction
// carried down the pipeline, and the training update presented to the BPU.
package bpu_correct_queue_pkg;

    localparam int BPU_CQ_DEPTH = 8;

    typedef enum logic [2:0] {
        BR_NONE     = 3'd0,
        BR_COND     = 3'd1,
        BR_DIRECT   = 3'd2,
        BR_CALL     = 3'd3,
        BR_RET      = 3'd4,
        BR_INDIRECT = 3'd5
    } br_type_t;

    typedef struct packed {
        logic        is_branch;
        br_type_t    br_type;
        logic        taken;
        logic [31:0] target_pc;
        logic [1:0]  scnt;
        logic [7:0]  history;
    } predict_info_t;

    typedef struct packed {
        logic        update;
        logic [31:0] pc;
        logic [31:0] target_pc;
        br_type_t    branch_type;
        logic        is_branch;
        logic        taken;
        logic        type_miss;
        logic        target_miss;
        logic [1:0]  scnt;
        logic [7:0]  history;
    } correct_info_t;

endpackage

// File: rtl/bpu_cq_classify.sv
// Combinational classifier for one retired slot: builds the BPU update entry and
// flags type, target and direction mispredictions.
module bpu_cq_classify
    import bpu_correct_queue_pkg::*;
(
    input  logic          [31:0] pc_i,
    input  predict_info_t        pred_i,
    input  logic                 is_branch_i,
    input  br_type_t             br_type_i,
    input  logic                 taken_i,
    input  logic          [31:0] target_i,
    output correct_info_t        entry_o,
    output logic                 type_miss_o,
    output logic                 target_miss_o,
    output logic                 dir_miss_o
);

    always_comb begin
        type_miss_o   = (pred_i.is_branch != is_branch_i) |
                        (is_branch_i & (pred_i.br_type != br_type_i));
        // A not-taken branch never redirects, so its target cannot be wrong.
        target_miss_o = is_branch_i & taken_i & (pred_i.target_pc != target_i);
        dir_miss_o    = pred_i.taken != taken_i;

        entry_o             = '0;
        entry_o.update      = 1'b1;
        entry_o.pc          = pc_i;
        entry_o.target_pc   = target_i;
        entry_o.branch_type = br_type_i;
        entry_o.is_branch   = is_branch_i;
        entry_o.taken       = taken_i;
        entry_o.type_miss   = type_miss_o;
        entry_o.target_miss = target_miss_o;
        entry_o.scnt        = pred_i.scnt;
        entry_o.history     = pred_i.history;
    end

endmodule

// File: rtl/bpu_correct_queue.sv
// Collects up to two retired slots per cycle into an in-order FIFO and drains one
// BPU training update per cycle on slot 0 of correct_infos_o.
module bpu_correct_queue
    import bpu_correct_queue_pkg::*;
#(
    parameter int DEPTH = BPU_CQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic          [1:0]       commit_valid_i,
    input  logic          [1:0][31:0] commit_pc_i,
    input  predict_info_t [1:0]       commit_pred_i,
    input  logic          [1:0]       commit_is_branch_i,
    input  br_type_t      [1:0]       commit_br_type_i,
    input  logic          [1:0]       commit_taken_i,
    input  logic          [1:0][31:0] commit_target_i,
    output logic                      commit_ready_o,
    output correct_info_t [1:0]       correct_infos_o,
    output logic          [31:0]      miss_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_addr;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   miss_cnt_q, miss_cnt_d;
    logic [32:0]   miss_sum;
    logic [1:0]    push_n, miss_inc;
    logic          pop;

    correct_info_t entry [2];
    logic [1:0]    type_miss, target_miss, dir_miss, relevant, any_miss;

    correct_info_t mem_q [DEPTH];

    // Ready leaves room for a full two-slot push even when no pop is counted.
    assign commit_ready_o = (count_q <= READY_MAX);

    for (genvar g = 0; g < 2; g++) begin : g_slot
        bpu_cq_classify u_classify (
            .pc_i          (commit_pc_i[g]),
            .pred_i        (commit_pred_i[g]),
            .is_branch_i   (commit_is_branch_i[g]),
            .br_type_i     (commit_br_type_i[g]),
            .taken_i       (commit_taken_i[g]),
            .target_i      (commit_target_i[g]),
            .entry_o       (entry[g]),
            .type_miss_o   (type_miss[g]),
            .target_miss_o (target_miss[g]),
            .dir_miss_o    (dir_miss[g])
        );

        assign relevant[g] = commit_valid_i[g] & commit_ready_o &
                             (commit_is_branch_i[g] | commit_pred_i[g].is_branch);
        assign any_miss[g] = relevant[g] & (type_miss[g] | target_miss[g] | dir_miss[g]);
    end

    always_comb begin
        pop      = (count_q != '0);
        push_n   = {1'b0, relevant[0]} + {1'b0, relevant[1]};
        miss_inc = {1'b0, any_miss[0]} + {1'b0, any_miss[1]};
        // A lone slot 1 takes wr_ptr; it only shifts when slot 0 also pushes.
        wr1_addr = wr_ptr_q + PW'(relevant[0]);
        wr_ptr_d = wr_ptr_q + PW'(push_n);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_n) - CW'(pop);

        miss_sum   = {1'b0, miss_cnt_q} + 33'(miss_inc);
        miss_cnt_d = miss_sum[32] ? '1 : miss_sum[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            miss_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Storage is not reset; stale contents are hidden by count_q.
    always_ff @(posedge clk) begin
        if (relevant[0]) mem_q[wr_ptr_q] <= entry[0];
        if (relevant[1]) mem_q[wr1_addr] <= entry[1];
    end

    always_comb begin
        correct_infos_o = '0;
        if (count_q != '0) begin
            correct_infos_o[0]        = mem_q[rd_ptr_q];
            correct_infos_o[0].update = 1'b1;
        end
    end

    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_bpu_correct_queue.sv
// Randomized and directed bench for bpu_correct_queue against a queue-based
// reference model of the correction FIFO.
module tb_bpu_correct_queue;
    import bpu_correct_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int CI_W  = $bits(correct_info_t);

    logic                      clk;
    logic                      rst;
    logic          [1:0]       commit_valid_i;
    logic          [1:0][31:0] commit_pc_i;
    predict_info_t [1:0]       commit_pred_i;
    logic          [1:0]       commit_is_branch_i;
    br_type_t      [1:0]       commit_br_type_i;
    logic          [1:0]       commit_taken_i;
    logic          [1:0][31:0] commit_target_i;
    logic                      commit_ready_o;
    correct_info_t [1:0]       correct_infos_o;
    logic          [31:0]      miss_cnt_o;

    logic [CI_W-1:0] exp_q[$];
    logic [31:0]     exp_miss;
    int              n_tests;
    int              n_fail;

    bpu_correct_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .commit_valid_i     (commit_valid_i),
        .commit_pc_i        (commit_pc_i),
        .commit_pred_i      (commit_pred_i),
        .commit_is_branch_i (commit_is_branch_i),
        .commit_br_type_i   (commit_br_type_i),
        .commit_taken_i     (commit_taken_i),
        .commit_target_i    (commit_target_i),
        .commit_ready_o     (commit_ready_o),
        .correct_infos_o    (correct_infos_o),
        .miss_cnt_o         (miss_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit must never present valid slots while ready is low.
    always @(negedge clk) begin
        assert (rst || commit_valid_i == 2'b00 || commit_ready_o)
            else $error("FAIL hold_ready: valid slots presented while ready low");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference classification straight from the update rules.
    function automatic void make_entry(input int i, output logic [CI_W-1:0] ent, output logic miss);
        correct_info_t e;
        predict_info_t p;
        logic          br, tk;
        p  = commit_pred_i[i];
        br = commit_is_branch_i[i];
        tk = commit_taken_i[i];
        e  = '0;
        e.update      = 1'b1;
        e.pc          = commit_pc_i[i];
        e.target_pc   = commit_target_i[i];
        e.branch_type = commit_br_type_i[i];
        e.is_branch   = br;
        e.taken       = tk;
        e.type_miss   = (p.is_branch != br) || (br && (p.br_type != commit_br_type_i[i]));
        e.target_miss = br && tk && (p.target_pc != commit_target_i[i]);
        e.scnt        = p.scnt;
        e.history     = p.history;
        miss = e.type_miss || e.target_miss || (p.taken != tk);
        ent  = e;
    endfunction

    task automatic check_outputs();
        logic [CI_W-1:0] exp0;
        exp0 = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("out0", correct_infos_o[0], exp0);
        check("out1", correct_infos_o[1], '0);
        check("ready", commit_ready_o, (exp_q.size() <= DEPTH - 2));
        check("miss_cnt", miss_cnt_o, exp_miss);
    endtask

    // Advance the model over one clock with the currently driven inputs, then check.
    task automatic cycle();
        logic [CI_W-1:0] e;
        logic            m, rdy;
        rdy = (exp_q.size() <= DEPTH - 2);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            if (commit_valid_i[i] && rdy && (commit_is_branch_i[i] || commit_pred_i[i].is_branch)) begin
                make_entry(i, e, m);
                exp_q.push_back(e);
                if (m && exp_miss != 32'hFFFF_FFFF) exp_miss++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // ---------------- drivers ----------------
    task automatic set_idle();
        commit_valid_i     = '0;
        commit_pc_i        = '0;
        commit_pred_i      = '0;
        commit_is_branch_i = '0;
        commit_br_type_i   = {BR_NONE, BR_NONE};
        commit_taken_i     = '0;
        commit_target_i    = '0;
    endtask

    task automatic set_slot(input int i, input logic [31:0] pc, input logic br, input br_type_t bt,
                            input logic tk, input logic [31:0] tgt, input logic p_br,
                            input br_type_t p_bt, input logic p_tk, input logic [31:0] p_tgt);
        predict_info_t p;
        p = '0;
        p.is_branch = p_br;
        p.br_type   = p_bt;
        p.taken     = p_tk;
        p.target_pc = p_tgt;
        p.scnt      = 2'($urandom_range(0, 3));
        p.history   = 8'($urandom_range(0, 255));
        commit_valid_i[i]     = 1'b1;
        commit_pc_i[i]        = pc;
        commit_pred_i[i]      = p;
        commit_is_branch_i[i] = br;
        commit_br_type_i[i]   = bt;
        commit_taken_i[i]     = tk;
        commit_target_i[i]    = tgt;
    endtask

    task automatic rand_slot(input int i, input logic force_rel);
        logic        br, p_br, tk;
        br_type_t    bt, p_bt;
        logic [31:0] tgt, p_tgt;
        br    = force_rel ? 1'b1 : ($urandom_range(0, 3) != 0);
        bt    = br ? br_type_t'(3'($urandom_range(1, 5))) : BR_NONE;
        p_br  = ($urandom_range(0, 4) != 0) ? br : ~br;
        p_bt  = ($urandom_range(0, 3) != 0) ? bt : br_type_t'(3'($urandom_range(0, 5)));
        tk    = 1'($urandom_range(0, 1));
        tgt   = 32'h1c00_0000 + 32'($urandom_range(0, 15)) * 4;
        p_tgt = ($urandom_range(0, 2) != 0) ? tgt : 32'h1c00_0000 + 32'($urandom_range(0, 15)) * 4;
        set_slot(i, 32'h1c00_0000 + 32'($urandom_range(0, 255)) * 4, br, bt, tk, tgt,
                 p_br, p_bt, 1'($urandom_range(0, 1)), p_tgt);
        commit_valid_i[i] = force_rel ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        set_idle();
        for (int k = 0; k < 2 * DEPTH && exp_q.size() > 0; k++) cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        correct_info_t o;
        logic          saw_low;
        n_tests  = 0;
        n_fail   = 0;
        exp_miss = '0;
        rst      = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", correct_infos_o[0], '0);
        check("rst_out1", correct_infos_o[1], '0);
        check("rst_ready", commit_ready_o, 1'b1);
        check("rst_miss", miss_cnt_o, 32'd0);
        rst = 1'b0;

        // BEQ with direction miss only
        set_slot(0, 32'h1c00_0010, 1'b1, BR_COND, 1'b1, 32'h1c00_0040,
                 1'b1, BR_COND, 1'b0, 32'h1c00_0040);
        cycle();
        o = correct_infos_o[0];
        check("beq_update", o.update, 1'b1);
        check("beq_type_miss", o.type_miss, 1'b0);
        check("beq_target_miss", o.target_miss, 1'b0);
        check("beq_taken", o.taken, 1'b1);
        check("beq_miss_cnt", miss_cnt_o, 32'd1);
        set_idle();
        cycle();
        o = correct_infos_o[0];
        check("beq_drained", o.update, 1'b0);

        // Two branches in one cycle drain in order
        set_slot(0, 32'h100, 1'b1, BR_COND, 1'b0, 32'h180, 1'b1, BR_COND, 1'b0, 32'h180);
        set_slot(1, 32'h104, 1'b1, BR_COND, 1'b0, 32'h1c0, 1'b1, BR_COND, 1'b0, 32'h1c0);
        cycle();
        o = correct_infos_o[0];
        check("pair_first_pc", o.pc, 32'h100);
        set_idle();
        cycle();
        o = correct_infos_o[0];
        check("pair_second_pc", o.pc, 32'h104);
        cycle();

        // Non-branch slot 0 ignored, unpredicted JIRL in slot 1
        set_slot(0, 32'h200, 1'b0, BR_NONE, 1'b0, 32'h0, 1'b0, BR_NONE, 1'b0, 32'h0);
        set_slot(1, 32'h204, 1'b1, BR_RET, 1'b1, 32'h400, 1'b0, BR_NONE, 1'b0, 32'h0);
        cycle();
        o = correct_infos_o[0];
        check("jirl_type_miss", o.type_miss, 1'b1);
        check("jirl_br_type", o.branch_type, BR_RET);
        check("jirl_pc", o.pc, 32'h204);
        set_idle();
        cycle();
        o = correct_infos_o[0];
        check("jirl_single", o.update, 1'b0);

        // Target miss on a taken direct branch
        set_slot(0, 32'h300, 1'b1, BR_DIRECT, 1'b1, 32'h300, 1'b1, BR_DIRECT, 1'b1, 32'h200);
        cycle();
        o = correct_infos_o[0];
        check("tgt_target_miss", o.target_miss, 1'b1);
        check("tgt_target_pc", o.target_pc, 32'h300);
        drain();

        // Fill with two relevant slots per cycle across pointer wrap
        saw_low = 1'b0;
        for (int k = 0; k < 24; k++) begin
            set_idle();
            if (exp_q.size() <= DEPTH - 2) begin
                rand_slot(0, 1'b1);
                rand_slot(1, 1'b1);
            end
            cycle();
            if (!commit_ready_o) saw_low = 1'b1;
        end
        check("fill_ready_low", saw_low, 1'b1);
        drain();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            set_idle();
            if (exp_q.size() <= DEPTH - 2) begin
                rand_slot(0, 1'b0);
                rand_slot(1, 1'b0);
            end
            cycle();
        end
        drain();

        // Asynchronous reset with five entries in flight
        for (int k = 0; k < 4; k++) begin
            set_idle();
            rand_slot(0, 1'b1);
            rand_slot(1, 1'b1);
            cycle();
        end
        set_idle();
        rst = 1'b1;
        #1;
        check("arst_out0", correct_infos_o[0], '0);
        check("arst_out1", correct_infos_o[1], '0);
        check("arst_ready", commit_ready_o, 1'b1);
        check("arst_miss", miss_cnt_o, 32'd0);
        exp_q.delete();
        exp_miss = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        rand_slot(0, 1'b1);
        rand_slot(1, 1'b1);
        cycle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
